// File: rtl/params_pkg.sv
// Shared widths, device ids and bus controller state encoding.
// Imported by the bus controller, its interface and the testbench.
package params_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int NDEV_DEF = 7;
    localparam int DID_W    = 3;

    localparam logic [DID_W-1:0] DRAM   = 3'd0;
    localparam logic [DID_W-1:0] DROM   = 3'd1;
    localparam logic [DID_W-1:0] DUART  = 3'd2;
    localparam logic [DID_W-1:0] DTIMER = 3'd3;
    localparam logic [DID_W-1:0] DGPIO  = 3'd4;
    localparam logic [DID_W-1:0] DI2C   = 3'd5;
    localparam logic [DID_W-1:0] DSPI   = 3'd6;
    localparam logic [DID_W-1:0] DNON   = 3'd7;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_DEC,
        BS_ACC,
        BS_RESP
    } bus_state_t;

endpackage

// File: rtl/bus_ctrl_if.sv
// CPU request/response, decoder and device signals of the bus controller.
// master = bus_ctrl side, slave = CPU/decoder/device side.
interface bus_ctrl_if
    import params_pkg::*;
#(
    parameter int NDEV = NDEV_DEF
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_wr;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;

    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;

    logic                   dec_rd;
    logic                   dec_wr;
    logic [ADDR_W-1:0]      dec_addr;
    logic                   dec_hit;
    logic [DID_W-1:0]       dec_did;

    logic [NDEV-1:0]        dev_sel;
    logic                   dev_rd;
    logic                   dev_wr;
    logic [ADDR_W-1:0]      dev_addr;
    logic [DATA_W-1:0]      dev_wdata;
    logic [NDEV*DATA_W-1:0] dev_rdata;
    logic [NDEV-1:0]        dev_ack;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output dec_rd, dec_wr, dec_addr,
        input  dec_hit, dec_did,
        output dev_sel, dev_rd, dev_wr, dev_addr, dev_wdata,
        input  dev_rdata, dev_ack
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  dec_rd, dec_wr, dec_addr,
        output dec_hit, dec_did,
        input  dev_sel, dev_rd, dev_wr, dev_addr, dev_wdata,
        output dev_rdata, dev_ack
    );

endinterface

// File: rtl/bus_watchdog.sv
// Counts access cycles without ack; expire flags the last allowed cycle.
// Used by bus_ctrl only when BUS_TIMEOUT_EN is defined.
module bus_watchdog #(
    parameter  int TIMEOUT_CYC = 16,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is the cycle in which the TIMEOUT_CYC-th ack-less cycle completes.
    assign expire = inc && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_ctrl.sv
// Single-master bus transaction controller: IDLE -> DEC -> ACC -> RESP, one request at a time.
// Optional access timeout under BUS_TIMEOUT_EN; otherwise ACC waits for the device ack.
module bus_ctrl
    import params_pkg::*;
#(
    parameter int NDEV        = NDEV_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input logic        clk,
    input logic        rst,
    bus_ctrl_if.master bus
);

    bus_state_t        state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DID_W-1:0]  did_q, did_d;
    logic              dec_rd_q, dec_rd_d;
    logic              dec_wr_q, dec_wr_d;
    logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
    logic [NDEV-1:0]   dev_sel_q, dev_sel_d;
    logic              dev_rd_q, dev_rd_d;
    logic              dev_wr_q, dev_wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic ack;
    logic expire;

    assign ack = bus.dev_ack[did_q];

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == BS_DEC),
        .inc    ((state_q == BS_ACC) && !ack),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        did_d       = did_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            BS_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = BS_DEC;
                end
            end
            BS_DEC: begin
                // A hit on an id beyond the device table is treated as unmapped.
                if (!bus.dec_hit || (32'(bus.dec_did) >= NDEV)) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = BS_RESP;
                end else begin
                    did_d   = bus.dec_did;
                    state_d = BS_ACC;
                end
            end
            BS_ACC: begin
                if (ack) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wr_q ? '0 : bus.dev_rdata[did_q*DATA_W +: DATA_W];
                    state_d     = BS_RESP;
                end else if (expire) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = BS_RESP;
                end
            end
            BS_RESP: begin
                state_d = BS_IDLE;
            end
            default: begin
                state_d = BS_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are clean flops.
        dec_rd_d    = (state_d == BS_DEC) && !wr_d;
        dec_wr_d    = (state_d == BS_DEC) && wr_d;
        dec_addr_d  = (state_d == BS_DEC) ? addr_d : '0;
        dev_sel_d   = (state_d == BS_ACC) ? (NDEV'(1) << did_d) : '0;
        dev_rd_d    = (state_d == BS_ACC) && !wr_d;
        dev_wr_d    = (state_d == BS_ACC) && wr_d;
        rsp_valid_d = (state_d == BS_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BS_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            did_q       <= '0;
            dec_rd_q    <= 1'b0;
            dec_wr_q    <= 1'b0;
            dec_addr_q  <= '0;
            dev_sel_q   <= '0;
            dev_rd_q    <= 1'b0;
            dev_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            did_q       <= did_d;
            dec_rd_q    <= dec_rd_d;
            dec_wr_q    <= dec_wr_d;
            dec_addr_q  <= dec_addr_d;
            dev_sel_q   <= dev_sel_d;
            dev_rd_q    <= dev_rd_d;
            dev_wr_q    <= dev_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == BS_IDLE);
    assign bus.dec_rd    = dec_rd_q;
    assign bus.dec_wr    = dec_wr_q;
    assign bus.dec_addr  = dec_addr_q;
    assign bus.dev_sel   = dev_sel_q;
    assign bus.dev_rd    = dev_rd_q;
    assign bus.dev_wr    = dev_wr_q;
    assign bus.dev_addr  = addr_q;
    assign bus.dev_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
